mem_test_master: RTL and testbench
==================================

Name: mem_test_master

Overview:
- Initiator for the team's valid/ready single-port memory interface (valid, wr_rd_en, addr, wdata → ready, rdata).
- On a start pulse, writes a seeded pattern to every address, reads every address back, compares, and reports pass/fail with error count and first failing address.
- Sits between a host/test controller and the memory block as its only bus master.

Parameters:
DEPTH, 8, number of memory words; must match the attached memory
WIDTH, 2, data width in bits
ADDR_WIDTH, $clog2(DEPTH), address width (derived)
TIMEOUT_CYCLES, 16, cycles allowed waiting on a ready edge before abort (used only with the optional feature)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  start-test pulse; sampled only in IDLE
seed_i  input  WIDTH  pattern seed; latched when start is accepted
valid_o  output  1  memory request valid
wr_rd_en_o  output  1  1=write, 0=read
addr_o  output  ADDR_WIDTH  memory address
wdata_o  output  WIDTH  write data
ready_i  input  1  memory handshake acknowledge
rdata_i  input  WIDTH  memory read data, valid in a read when ready_i=1
busy_o  output  1  test in progress
done_o  output  1  one-cycle pulse at test end
pass_o  output  1  1 if last test had zero mismatches and no timeout
err_cnt_o  output  ADDR_WIDTH+1  mismatch count of last test
first_err_addr_o  output  ADDR_WIDTH  address of first mismatch; 0 if none
timeout_o  output  1  last test aborted on timeout

Behaviour:
- Reset (async, rst_ni=0): all outputs 0; state IDLE; address counter 0; latched seed 0. Takes effect immediately, including mid-transaction.
- Pattern: data(a) = (a + seed) mod 2^WIDTH, computed WIDTH bits wide.
- States: IDLE, WR_REQ, WR_REL, RD_REQ, RD_REL, DONE.
- IDLE: valid_o=0, busy_o=0. If start_i=1, latch seed, clear err_cnt_o/first_err_addr_o/pass_o/timeout_o, addr=0, busy_o=1, go to WR_REQ.
- WR_REQ: valid_o=1, wr_rd_en_o=1, addr_o=addr, wdata_o=data(addr). Hold until ready_i=1, then go to WR_REL.
- WR_REL: valid_o=0. Wait for ready_i=0 so the memory has dropped its acknowledge. Then:
  - if addr=DEPTH-1: addr=0, go to RD_REQ;
  - else addr+1, go to WR_REQ.
- RD_REQ: valid_o=1, wr_rd_en_o=0, addr_o=addr. In the cycle ready_i=1, compare rdata_i with data(addr).
  - On mismatch: err_cnt+1. If this is the first error, first_err_addr_o=addr.
  - Go to RD_REL.
- RD_REL: valid_o=0. Wait for ready_i=0. Then:
  - if addr=DEPTH-1: go to DONE;
  - else addr+1, go to RD_REQ.
- DONE: done_o=1 for exactly one cycle; busy_o=0; pass_o=(err_cnt==0 && !timeout). Go to IDLE.
- Result outputs hold until the next accepted start.
- Each transaction takes 4 cycles with a registered-ready memory. One full test takes 2*DEPTH*4 + 2 cycles.
- Outputs wr_rd_en_o, addr_o and wdata_o are stable for the whole time valid_o=1.
- start_i is ignored outside IDLE, including in DONE.
- addr_o does not wrap mid-phase; wrap-around is only at the DEPTH-1 boundary described above.
- Repeated acknowledge on the release edge (memory sees valid one extra cycle) is harmless and must not be counted twice.

Optional Feature:
- Macro: MEM_TEST_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on each entry to a REQ or REL state and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES: valid_o=0, timeout_o=1, go to DONE, and pass_o=0 in DONE.
- Not defined: no counter exists; timeout_o is tied to 0; REQ/REL wait forever.

Test Plan:
1. Reset → assert rst_ni=0 mid-cycle with clock stopped → all outputs 0 immediately; after release, valid_o=0 and busy_o=0.
2. Healthy memory, DEPTH=8, WIDTH=2, seed_i=1, start pulse:
   - writes addr 0..7 with data 1,2,3,0,1,2,3,0, then 8 reads;
   - done_o pulses 66 cycles after start;
   - pass_o=1, err_cnt_o=0.
3. Memory model forces rdata_i=0 on read of addr 5 (expected 2) → err_cnt_o=1, first_err_addr_o=5, pass_o=0.
4. Pulse start_i again during the write phase and in the DONE cycle → both ignored, and the access sequence is unchanged. Start in the next IDLE cycle → new test with a cleared err_cnt_o.
5. Drop rst_ni low during the read of addr 3 → valid_o and busy_o go to 0 immediately. A new start begins with a write to addr 0.
6. With MEM_TEST_MASTER_TIMEOUT_EN defined and ready_i held at 0 → 16 cycles into WR_REQ, timeout_o=1, done_o pulses, pass_o=0. Without the macro, the master stays in WR_REQ indefinitely.

Source files
------------

// File: rtl/mem_test_master.sv
// mem_test_master
//   Bus master for the valid/ready single-port memory interface. A start
//   pulse launches one full test:
//     1. write data(a) = (a + seed) mod 2^WIDTH to every address,
//     2. read every address back and compare it with the same pattern,
//     3. report pass/fail, the mismatch count and the first failing address.
//
//   Every transaction is a four-phase handshake. The master raises valid
//   (REQ), waits for ready, drops valid (REL) and then waits for ready to
//   fall before it moves on. Because of that final wait, a memory that
//   acknowledges once more on the release edge cannot make one transaction
//   count twice.
//
//   Optional feature: define MEM_TEST_MASTER_TIMEOUT_EN to abort the test
//   when any REQ/REL state lasts TIMEOUT_CYCLES cycles. Without the macro,
//   timeout_o is tied to 0 and the master waits indefinitely.
//
// Ports
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   start_i           start-test pulse; sampled only in IDLE
//   seed_i            pattern seed; latched when start is accepted
//   valid_o           memory request valid
//   wr_rd_en_o        1 = write, 0 = read
//   addr_o            memory address
//   wdata_o           write data
//   ready_i           memory handshake acknowledge
//   rdata_i           read data, valid while ready_i=1 during a read
//   busy_o            test in progress
//   done_o            one-cycle pulse at the end of a test
//   pass_o            last test had no mismatch and no timeout
//   err_cnt_o         mismatch count of the last test
//   first_err_addr_o  address of the first mismatch (0 if none)
//   timeout_o         last test was aborted on timeout
module mem_test_master #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned WIDTH          = 2,
  parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH),
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      seed_i,
  output logic                  valid_o,
  output logic                  wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      wdata_o,
  input  logic                  ready_i,
  input  logic [WIDTH-1:0]      rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ADDR_WIDTH:0]   err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  timeout_o
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_REL, S_RD_REQ, S_RD_REL, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic [CW-1:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic                  wait_expired;
  logic [WIDTH-1:0]      exp_data;

  // Test pattern: address plus seed, wrapped to WIDTH bits.
  function automatic logic [WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                               input logic [WIDTH-1:0]      s);
    logic [WIDTH-1:0] a_w;
    a_w = WIDTH'(a);
    return a_w + s;
  endfunction

  assign exp_data = pattern(addr_q, seed_q);

`ifdef MEM_TEST_MASTER_TIMEOUT_EN
  localparam int unsigned WC_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WC_W-1:0] wait_q, wait_d;

  // The counter is 0 in the first cycle of a state, so the value
  // TIMEOUT_CYCLES-1 marks the last cycle allowed in that state.
  assign wait_expired = (wait_q == WC_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_d = wait_q + WC_W'(1);
    if (state_d != state_q) begin
      wait_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign wait_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    seed_d      = seed_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          seed_d      = seed_i;
          err_cnt_d   = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          addr_d      = '0;
          state_d     = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (ready_i) begin
          state_d = S_WR_REL;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_WR_REL: begin
        if (!ready_i) begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = S_RD_REQ;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_WR_REQ;
          end
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_RD_REQ: begin
        // The compare happens only in the cycle that leaves RD_REQ, so a
        // lingering ready during RD_REL is never compared again.
        if (ready_i) begin
          if (rdata_i != exp_data) begin
            err_cnt_d = err_cnt_q + CW'(1);
            if (err_cnt_q == '0) begin
              first_err_d = addr_q;
            end
          end
          state_d = S_RD_REL;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_RD_REL: begin
        if (!ready_i) begin
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_RD_REQ;
          end
        end else if (wait_expired) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Latch the verdict on entry to DONE so pass_o is valid with done_o.
    if (state_d == S_DONE && state_q != S_DONE) begin
      pass_d = (err_cnt_d == '0) && !timeout_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      seed_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      seed_q      <= seed_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  // Bus outputs decode directly from registered state, so they stay
  // constant for the whole of each REQ state.
  assign valid_o          = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
  assign wr_rd_en_o       = (state_q == S_WR_REQ);
  assign addr_o           = addr_q;
  assign wdata_o          = (state_q == S_WR_REQ) ? exp_data : '0;
  assign busy_o           = (state_q == S_WR_REQ) || (state_q == S_WR_REL) ||
                            (state_q == S_RD_REQ) || (state_q == S_RD_REL);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = pass_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_mem_test_master.sv
module tb_mem_test_master;

  localparam int DEPTH = 8;
  localparam int WIDTH = 2;
  localparam int AW    = 3;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             clk_en = 1'b0;
  logic             rst_ni = 1'b1;
  logic             start_i = 1'b0;
  logic [WIDTH-1:0] seed_i = '0;
  logic             valid_o, wr_rd_en_o;
  logic [AW-1:0]    addr_o;
  logic [WIDTH-1:0] wdata_o;
  logic             ready_i;
  logic [WIDTH-1:0] rdata_i;
  logic             busy_o, done_o, pass_o, timeout_o;
  logic [AW:0]      err_cnt_o;
  logic [AW-1:0]    first_err_addr_o;

  mem_test_master #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .seed_i(seed_i),
    .valid_o(valid_o), .wr_rd_en_o(wr_rd_en_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .ready_i(ready_i), .rdata_i(rdata_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .err_cnt_o(err_cnt_o), .first_err_addr_o(first_err_addr_o),
    .timeout_o(timeout_o)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Memory model: ready is the registered copy of valid, optionally with
  // random extra latency or held low entirely.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] cur_mask = '0;
  logic [WIDTH-1:0] cur_cval = '0;
  logic             rand_lat = 1'b0;
  logic             hold_ready0 = 1'b0;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_i <= 1'b0;
      rdata_i <= '0;
    end else begin
      if (hold_ready0) ready_i <= 1'b0;
      else             ready_i <= valid_o && (!rand_lat || ($urandom_range(0, 1) == 1));
      if (valid_o && wr_rd_en_o) mem[addr_o] <= wdata_o;
      rdata_i <= cur_mask[addr_o] ? cur_cval : mem[addr_o];
    end
  end

  // Reference model: the ordered list of accesses a test must perform and
  // the verdict it must report.
  typedef struct {
    logic             wr;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
  } acc_t;
  acc_t exp_q[$];
  int   exp_err, exp_first;
  logic exp_pass, exp_timeout;

  logic             rec_en = 1'b0;
  logic [WIDTH-1:0] obs_w [DEPTH];

  logic             prev_valid, prev_done;
  logic [AW+WIDTH:0] prev_bus;

  // Compare process: every handshake, request stability, and the verdict.
  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_valid <= 1'b0;
      prev_done  <= 1'b0;
    end else begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_access", {wr_rd_en_o, addr_o}, 32'hFFFF);
        end else begin
          acc_t e;
          e = exp_q.pop_front();
          if (e.wr) chk("write_access", {wr_rd_en_o, addr_o, wdata_o}, {e.wr, e.a, e.d});
          else      chk("read_access", {wr_rd_en_o, addr_o}, {e.wr, e.a});
          if (rec_en && wr_rd_en_o) obs_w[addr_o] <= wdata_o;
        end
      end
      if (valid_o && prev_valid) chk("req_stable", {wr_rd_en_o, addr_o, wdata_o}, prev_bus);
      if (done_o) begin
        chk("done_one_cycle", prev_done, 0);
        chk("done_not_busy", busy_o, 0);
        chk("pass", pass_o, exp_pass);
        chk("err_cnt", err_cnt_o, exp_err);
        chk("first_err_addr", first_err_addr_o, exp_first);
        chk("timeout", timeout_o, exp_timeout);
        if (!exp_timeout) chk("accesses_left", exp_q.size(), 0);
        exp_q.delete();
      end
      prev_valid <= valid_o;
      prev_done  <= done_o;
      prev_bus   <= {wr_rd_en_o, addr_o, wdata_o};
    end
  end

  // Builds the model for one test, then drives the start pulse.
  // Called right after a falling edge; returns one falling edge later.
  task automatic start_test(input logic [WIDTH-1:0] seed, input logic [DEPTH-1:0] mask,
                            input logic [WIDTH-1:0] cval);
    int errs, first;
    acc_t e;
    logic [WIDTH-1:0] pat, ret;
    cur_mask = mask;
    cur_cval = cval;
    exp_q.delete();
    errs  = 0;
    first = 0;
    for (int a = 0; a < DEPTH; a++) begin
      e.wr = 1'b1; e.a = AW'(a); e.d = WIDTH'((a + int'(seed)) % (1 << WIDTH));
      exp_q.push_back(e);
    end
    for (int a = 0; a < DEPTH; a++) begin
      pat = WIDTH'((a + int'(seed)) % (1 << WIDTH));
      ret = mask[a] ? cval : pat;
      if (ret != pat) begin
        if (errs == 0) first = a;
        errs++;
      end
      e.wr = 1'b0; e.a = AW'(a); e.d = '0;
      exp_q.push_back(e);
    end
    exp_err     = errs;
    exp_first   = first;
    exp_pass    = (errs == 0);
    exp_timeout = 1'b0;
    seed_i  = seed;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    chk("err_cleared_on_start", err_cnt_o, 0);
    chk("pass_cleared_on_start", pass_o, 0);
    chk("timeout_cleared_on_start", timeout_o, 0);
  endtask

  // Waits for done_o with a cycle bound. cyc counts the start cycle as 0.
  task automatic wait_done(input int bound, output int cyc);
    cyc = 1;
    while (!done_o) begin
      if (cyc >= bound) begin
        chk("done_wait_bound", cyc, 0);
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [WIDTH-1:0] lit [DEPTH];
  int cyc;

  initial begin
    lit = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset with the clock stopped
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_bus", {wr_rd_en_o, addr_o, wdata_o}, 0);
    chk("rst_results", {pass_o, err_cnt_o, first_err_addr_o, timeout_o}, 0);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", valid_o, 0);
    chk("post_rst_busy", busy_o, 0);

    // Healthy memory, seed 1: exact latency and literal data
    rec_en = 1'b1;
    start_test(2'd1, '0, '0);
    wait_done(500, cyc);
    // Start cycle + 64 transaction cycles, DONE lands in the 66th cycle.
    chk("done_latency", cyc, 65);
    chk("healthy_pass", pass_o, 1);
    chk("healthy_err", err_cnt_o, 0);
    rec_en = 1'b0;
    for (int a = 0; a < DEPTH; a++) chk("write_pattern_literal", obs_w[a], lit[a]);
    @(negedge clk);

    // Read of addr 5 corrupted to 0, plus ignored start pulses
    start_test(2'd1, 8'b0010_0000, 2'd0);
    repeat (6) @(negedge clk);
    seed_i  = 2'd3;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(500, cyc);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("corrupt_err_cnt", err_cnt_o, 1);
    chk("corrupt_first", first_err_addr_o, 5);
    chk("corrupt_pass", pass_o, 0);
    chk("start_in_done_ignored", busy_o, 0);
    start_test(2'd2, '0, '0);
    wait_done(500, cyc);
    chk("rerun_pass", pass_o, 1);
    @(negedge clk);

    // Reset in the middle of the read of addr 3
    start_test(WIDTH'($urandom_range(0, 3)), '0, '0);
    cyc = 0;
    while (!(valid_o && !wr_rd_en_o && addr_o == 3) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_read3", {valid_o, wr_rd_en_o, addr_o}, {1'b1, 1'b0, 3'd3});
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    exp_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    start_test(WIDTH'($urandom_range(0, 3)), '0, '0);
    chk("restart_first_access", {valid_o, wr_rd_en_o, addr_o}, {1'b1, 1'b1, 3'd0});
    wait_done(500, cyc);
    @(negedge clk);

    // Memory never acknowledges
    hold_ready0 = 1'b1;
    start_test(2'd0, '0, '0);
`ifdef MEM_TEST_MASTER_TIMEOUT_EN
    exp_timeout = 1'b1;
    exp_pass    = 1'b0;
    exp_err     = 0;
    exp_first   = 0;
    wait_done(100, cyc);
    chk("timeout_latency", cyc, TO + 1);
    chk("timeout_flag", timeout_o, 1);
    chk("timeout_pass", pass_o, 0);
    hold_ready0 = 1'b0;
    @(negedge clk);
`else
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_o) cyc++;
      @(negedge clk);
    end
    chk("stall_no_done", cyc, 0);
    chk("stall_in_wr_req", {valid_o, wr_rd_en_o, addr_o, timeout_o}, {1'b1, 1'b1, 3'd0, 1'b0});
    hold_ready0 = 1'b0;
    wait_done(500, cyc);
    @(negedge clk);
`endif

    // Randomized tests
    for (int t = 0; t < 10; t++) begin
      rand_lat = 1'($urandom_range(0, 1));
      start_test(WIDTH'($urandom_range(0, 3)), DEPTH'($urandom_range(0, 255)),
                 WIDTH'($urandom_range(0, 3)));
      wait_done(2000, cyc);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rand_lat = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
